// File: rtl/direction_gen.sv
// direction_gen: PS/2 scan codes to paced, reversal-filtered move commands.
// Define DIRECTION_GEN_WASD_EN to also steer with unprefixed WASD make codes.
package game_pkg;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } directions;

  function automatic directions opposite(input directions d);
    directions o;
    case (d)
      UP:      o = DOWN;
      DOWN:    o = UP;
      LEFT:    o = RIGHT;
      RIGHT:   o = LEFT;
      default: o = WAIT;
    endcase
    return o;
  endfunction

endpackage

module direction_gen
  import game_pkg::*;
#(
  parameter int unsigned STEP_CYCLES   = 6_500_000,
  parameter directions   START_HEADING = UP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       enable,
  output directions  direction,
  output directions  heading,
  output logic       step
);

  localparam int unsigned CntW = $clog2(STEP_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

  localparam logic [7:0] CodeExt = 8'hE0;
  localparam logic [7:0] CodeBrk = 8'hF0;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } scan_state_e;

  scan_state_e     state_q, state_d;
  directions       heading_q, heading_d;
  directions       committed_q, committed_d;
  directions       dir_q, dir_d;
  logic            step_q, step_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic      dec_valid;
  directions dec_dir;
  logic      step_now;
  directions ref_dir;
  logic      accept;

  // Scan-code state machine and make-code decoder
  always_comb begin
    state_d   = state_q;
    dec_valid = 1'b0;
    dec_dir   = WAIT;
    if (scan_valid) begin
      unique case (state_q)
        StIdle: begin
          if (scan_code == CodeExt) begin
            state_d = StExt;
          end else if (scan_code == CodeBrk) begin
            state_d = StBrk;
          end else begin
            state_d = StIdle;
`ifdef DIRECTION_GEN_WASD_EN
            case (scan_code)
              8'h1D:   begin dec_valid = 1'b1; dec_dir = UP;    end
              8'h1B:   begin dec_valid = 1'b1; dec_dir = DOWN;  end
              8'h1C:   begin dec_valid = 1'b1; dec_dir = LEFT;  end
              8'h23:   begin dec_valid = 1'b1; dec_dir = RIGHT; end
              default: ;
            endcase
`else
            dec_valid = 1'b0;
`endif
          end
        end
        StExt: begin
          state_d = StIdle;
          case (scan_code)
            8'h75:   begin dec_valid = 1'b1; dec_dir = UP;    end
            8'h72:   begin dec_valid = 1'b1; dec_dir = DOWN;  end
            8'h6B:   begin dec_valid = 1'b1; dec_dir = LEFT;  end
            8'h74:   begin dec_valid = 1'b1; dec_dir = RIGHT; end
            CodeExt: state_d = StExt;
            CodeBrk: state_d = StExtBrk;
            default: ;
          endcase
        end
        StBrk, StExtBrk: state_d = StIdle;
        default:         state_d = StIdle;
      endcase
    end
  end

  // On a step edge the reversal check uses the direction being emitted, so a
  // fast two-key U-turn inside one step period is still rejected.
  always_comb begin
    step_now = enable && (cnt_q == CntLast);
    ref_dir  = step_now ? heading_q : committed_q;
    accept   = dec_valid && (dec_dir != opposite(ref_dir));
  end

  always_comb begin
    heading_d   = heading_q;
    committed_d = committed_q;
    dir_d       = WAIT;
    step_d      = 1'b0;
    cnt_d       = '0;
    if (accept) begin
      heading_d = dec_dir;
    end
    if (step_now) begin
      dir_d       = heading_q;
      step_d      = 1'b1;
      committed_d = heading_q;
    end else if (enable) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      heading_q   <= START_HEADING;
      committed_q <= START_HEADING;
      dir_q       <= WAIT;
      step_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      heading_q   <= heading_d;
      committed_q <= committed_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
    end
  end

  assign direction = dir_q;
  assign heading   = heading_q;
  assign step      = step_q;

  a_step_matches_dir : assert property (@(posedge clk) disable iff (!rst)
    step == (direction != WAIT));
  a_heading_valid : assert property (@(posedge clk) disable iff (!rst)
    heading != WAIT);

endmodule

// File: tb/tb_direction_gen.sv
// Randomized and directed bench for direction_gen against a sequence-level model.
// Honours DIRECTION_GEN_WASD_EN the same way the design does.
module tb_direction_gen;
  import game_pkg::*;

  localparam int unsigned StepCycles = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       enable = 1'b0;
  directions  direction;
  directions  heading;
  logic       step;

  direction_gen #(
    .STEP_CYCLES  (StepCycles),
    .START_HEADING(UP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .enable    (enable),
    .direction (direction),
    .heading   (heading),
    .step      (step)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  directions   m_dir = WAIT;
  logic        m_step = 1'b0;
  directions   m_heading = UP;
  directions   m_committed = UP;
  int unsigned m_cnt = 0;
  logic [7:0]  pend[$];

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic directions model_opp(input directions d);
    if (d == UP) return DOWN;
    if (d == DOWN) return UP;
    if (d == LEFT) return RIGHT;
    if (d == RIGHT) return LEFT;
    return WAIT;
  endfunction

  function automatic directions arrow_of(input logic [7:0] b);
    if (b == 8'h75) return UP;
    if (b == 8'h72) return DOWN;
    if (b == 8'h6B) return LEFT;
    if (b == 8'h74) return RIGHT;
    return WAIT;
  endfunction

  function automatic directions wasd_of(input logic [7:0] b);
`ifdef DIRECTION_GEN_WASD_EN
    if (b == 8'h1D) return UP;
    if (b == 8'h1B) return DOWN;
    if (b == 8'h1C) return LEFT;
    if (b == 8'h23) return RIGHT;
`endif
    return WAIT;
  endfunction

  // Collect bytes of the current key sequence; return the decoded make direction or WAIT.
  task automatic model_byte(input logic [7:0] b, output directions d);
    d = WAIT;
    pend.push_back(b);
    if (pend.size() == 1) begin
      if (b != 8'hE0 && b != 8'hF0) begin
        d = wasd_of(b);
        pend.delete();
      end
    end else if (pend[0] == 8'hF0) begin
      pend.delete();
    end else if (pend.size() == 2) begin
      if (b == 8'hE0) begin
        void'(pend.pop_back());
      end else if (b != 8'hF0) begin
        d = arrow_of(b);
        pend.delete();
      end
    end else begin
      pend.delete();
    end
  endtask

  task automatic model_edge();
    directions d;
    directions ref_dir;
    directions nh;
    logic      sn;
    if (!rst) begin
      m_dir = WAIT;
      m_step = 1'b0;
      m_heading = UP;
      m_committed = UP;
      m_cnt = 0;
      pend.delete();
    end else begin
      sn = enable && (m_cnt == StepCycles - 1);
      ref_dir = sn ? m_heading : m_committed;
      nh = m_heading;
      if (scan_valid) begin
        model_byte(scan_code, d);
        if (d != WAIT && d != model_opp(ref_dir)) nh = d;
      end
      m_dir = sn ? m_heading : WAIT;
      m_step = sn;
      if (sn) m_committed = m_heading;
      m_heading = nh;
      m_cnt = (enable && !sn) ? m_cnt + 1 : 0;
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] c, input logic e);
    @(negedge clk);
    rst = r;
    scan_valid = v;
    scan_code = c;
    enable = e;
    @(posedge clk);
    model_edge();
    #1;
    check_val("direction", int'(direction), int'(m_dir));
    check_val("step", int'(step), int'(m_step));
    check_val("heading", int'(heading), int'(m_heading));
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic key(input logic [7:0] c, input logic e);
    cycle(1'b1, 1'b1, c, e);
  endtask

  logic [7:0] pool[11] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                           8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h00};

  initial begin
    int first_k;
    int unsigned idx;
    logic [7:0] b;

    // Reset state and plain stepping: steps in cycles 4, 8, 12
    do_reset();
    check_val("rst_heading", int'(heading), int'(UP));
    check_val("rst_step", int'(step), 0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      check_val("step_pos", int'(step), ((i + 1) % 4 == 0) ? 1 : 0);
      if ((i + 1) % 4 == 0) check_val("step_dir", int'(direction), int'(UP));
    end

    // E0 74 turns right one cycle after the final byte
    key(8'hE0, 1'b1);
    key(8'h74, 1'b1);
    check_val("right_heading", int'(heading), int'(RIGHT));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      if (step) check_val("right_step", int'(direction), int'(RIGHT));
    end

    // Reversal rejected against committed UP, including a two-key U-turn
    do_reset();
    key(8'hE0, 1'b0);
    key(8'h72, 1'b0);
    check_val("rev_ignored", int'(heading), int'(UP));
    key(8'hE0, 1'b0);
    key(8'h74, 1'b0);
    key(8'hE0, 1'b0);
    key(8'h72, 1'b0);
    check_val("uturn_block", int'(heading), int'(RIGHT));
    first_k = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      if (step && first_k == 0) begin
        first_k = k;
        check_val("uturn_step", int'(direction), int'(RIGHT));
      end
    end
    check_val("uturn_lat", int'(first_k), StepCycles);

    // Break codes do not steer and return to idle
    do_reset();
    key(8'hE0, 1'b0);
    key(8'hF0, 1'b0);
    key(8'h75, 1'b0);
    key(8'h74, 1'b0);
    check_val("brk_nochange", int'(heading), int'(UP));
    key(8'hE0, 1'b0);
    key(8'h6B, 1'b0);
    check_val("brk_idle", int'(heading), int'(LEFT));
    do_reset();
    key(8'h1C, 1'b0);
`ifdef DIRECTION_GEN_WASD_EN
    check_val("wasd_left", int'(heading), int'(LEFT));
    key(8'hF0, 1'b0);
    key(8'h1D, 1'b0);
    check_val("wasd_brk", int'(heading), int'(LEFT));
`else
    check_val("wasd_off", int'(heading), int'(UP));
`endif

    // Enable dropped at count 2, then re-raised
    do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      check_val("dis_wait", int'(direction), int'(WAIT));
    end
    first_k = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      if (step && first_k == 0) first_k = k;
    end
    check_val("reen_lat", int'(first_k), StepCycles);

    // Reset mid-prefix discards the pending E0
    do_reset();
    key(8'hE0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    key(8'h74, 1'b0);
    check_val("rst_prefix", int'(heading), int'(UP));

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      idx = $urandom_range(0, 10);
      b = pool[idx];
      if (idx == 10) b = 8'($urandom);
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1), b,
            ($urandom_range(0, 9) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
